// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter.
// Groups the CPU port, debug port, RAM port and I/O device signals.
//   slave  : the arbiter's view (CPU/debug requests in, RAM/IO controls out)
//   master : the environment's view (CPU, debug host, RAM and devices)
interface mem_bus_arbiter_if;
    // CPU port
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_r;
    logic        cpu_w;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // Debug port
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    // RAM port (synchronous write, asynchronous read)
    logic [7:0]  mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_spo;
    // I/O devices
    logic [31:0] io_in_data;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_out_data;
    logic        io_out_valid;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_r, cpu_w,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_a, mem_d, mem_we,
        input  mem_spo,
        input  io_in_data, io_in_valid,
        output io_in_ready, io_out_data, io_out_valid
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_r, cpu_w,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_a, mem_d, mem_we,
        output mem_spo,
        output io_in_data, io_in_valid,
        input  io_in_ready, io_out_data, io_out_valid
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between a CPU and a debug port.
// The CPU owns the RAM/IO path whenever debug is not being served; a debug
// request waits for an idle CPU cycle and, after STARVE_LIMIT blocked cycles,
// stalls the CPU for one cycle to force its access through.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_bus_arbiter_if.slave (CPU, debug, RAM and I/O signals)
// Word address map: 0x00-0xFB RAM, 0xFC IO_OUT, 0xFD IN_DATA (ro),
// 0xFE STATUS (ro, bit0 in_full, bit1 arbiter busy), 0xFF reads 0.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 15
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [7:0] AddrIoOut   = 8'hFC;
    localparam logic [7:0] AddrInData  = 8'hFD;
    localparam logic [7:0] AddrStatus  = 8'hFE;
    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StStall, StAck} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        cpu_busy;
    logic        dbg_serve;
    logic        cpu_stall;
    logic        dbg_ack;

    logic [7:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_we;
    logic        acc_is_ram;
    logic [31:0] rd_data;

    logic        in_full_q, in_full_d;
    logic [31:0] in_data_q, in_data_d;
    logic [31:0] io_out_q, io_out_d;
    logic        io_out_valid_q, io_out_valid_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        io_out_wr;
    logic        cpu_in_read;

    assign cpu_busy = bus.cpu_r | bus.cpu_w;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.dbg_req) begin
                    if (cpu_busy) begin
                        state_d = StWait;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StWait: begin
                if (!bus.dbg_req) begin
                    state_d = StIdle;
                end else if (!cpu_busy) begin
                    state_d = StAck;
                end else begin
                    // cnt counts WAIT cycles, so this fires on the STARVE_LIMIT-th one
                    if (cnt_q >= StarveLimit) begin
                        state_d = StStall;
                    end
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StStall: state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            cnt_d = '0;
        end
    end

    // FSM outputs
    always_comb begin
        cpu_stall = 1'b0;
        dbg_ack   = 1'b0;
        dbg_serve = 1'b0;
        unique case (state_q)
            StIdle:  dbg_serve = bus.dbg_req & ~cpu_busy;
            StWait:  dbg_serve = bus.dbg_req & ~cpu_busy;
            StStall: begin
                cpu_stall = 1'b1;
                dbg_serve = 1'b1;
            end
            StAck:   dbg_ack = 1'b1;
            default: ;
        endcase
    end

    // Shared RAM/IO path; serving debug also suppresses CPU writes in STALL
    always_comb begin
        acc_addr   = dbg_serve ? bus.dbg_addr  : bus.cpu_addr;
        acc_wdata  = dbg_serve ? bus.dbg_wdata : bus.cpu_wdata;
        acc_we     = dbg_serve ? bus.dbg_we    : bus.cpu_w;
        acc_is_ram = acc_addr < AddrIoOut;
    end

    always_comb begin
        rd_data = '0;
        if (acc_is_ram) begin
            rd_data = bus.mem_spo;
        end else begin
            case (acc_addr)
                AddrIoOut:  rd_data = io_out_q;
                AddrInData: rd_data = in_data_q;
                AddrStatus: rd_data = {30'd0, state_q != StIdle, in_full_q};
                default:    rd_data = '0;
            endcase
        end
    end

    assign io_out_wr   = acc_we & (acc_addr == AddrIoOut);
    // Only a CPU read drains the input register; debug reads are non-destructive
    assign cpu_in_read = ~dbg_serve & bus.cpu_r & (acc_addr == AddrInData);

    // I/O and debug data next state
    always_comb begin
        in_full_d      = in_full_q;
        in_data_d      = in_data_q;
        io_out_d       = io_out_q;
        io_out_valid_d = io_out_wr;
        dbg_rdata_d    = dbg_rdata_q;
        if (cpu_in_read) begin
            in_full_d = 1'b0;
        end
        // Ready is the registered !in_full, so a same-cycle drain cannot capture
        if (bus.io_in_valid && !in_full_q) begin
            in_full_d = 1'b1;
            in_data_d = bus.io_in_data;
        end
        if (io_out_wr) begin
            io_out_d = acc_wdata;
        end
        if (dbg_serve) begin
            dbg_rdata_d = rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_full_q      <= 1'b0;
            in_data_q      <= '0;
            io_out_q       <= '0;
            io_out_valid_q <= 1'b0;
            dbg_rdata_q    <= '0;
        end else begin
            in_full_q      <= in_full_d;
            in_data_q      <= in_data_d;
            io_out_q       <= io_out_d;
            io_out_valid_q <= io_out_valid_d;
            dbg_rdata_q    <= dbg_rdata_d;
        end
    end

    assign bus.mem_a        = acc_addr;
    assign bus.mem_d        = acc_wdata;
    // rst gates the strobe so an abandoned access cannot write at the next edge
    assign bus.mem_we       = acc_we & acc_is_ram & ~rst;
    assign bus.cpu_rdata    = dbg_serve ? 32'd0 : rd_data;
    assign bus.cpu_stall    = cpu_stall;
    assign bus.dbg_ack      = dbg_ack;
    assign bus.dbg_rdata    = dbg_rdata_q;
    assign bus.io_in_ready  = ~in_full_q;
    assign bus.io_out_data  = io_out_q;
    assign bus.io_out_valid = io_out_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    logic ram_clear;
    int   checks;
    int   errors;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } dbg_exp_t;

    dbg_exp_t    dbg_q[$];
    logic [31:0] io_q[$];
    logic [31:0] ram [256];

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(.STARVE_LIMIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8'h10] <= 32'hDEADBEEF;
        end else if (bus_if.mem_we) begin
            ram[bus_if.mem_a] <= bus_if.mem_d;
        end
    end
    assign bus_if.mem_spo = ram[bus_if.mem_a];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an output
    always @(negedge clk) begin
        dbg_exp_t e;
        logic [31:0] io_exp;
        if (!rst) begin
            if (bus_if.dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dbg_ack: got ack=1 expected ack=0");
                end else begin
                    e = dbg_q.pop_front();
                    if (e.is_read) begin
                        checks++;
                        if (bus_if.dbg_rdata !== e.data) begin
                            errors++;
                            $display("FAIL dbg_rdata: got %h expected %h", bus_if.dbg_rdata, e.data);
                        end
                    end
                end
            end
            if (bus_if.io_out_valid) begin
                if (io_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_io_out_valid: got valid=1 expected valid=0");
                end else begin
                    io_exp = io_q.pop_front();
                    checks++;
                    if (bus_if.io_out_data !== io_exp) begin
                        errors++;
                        $display("FAIL io_out_data: got %h expected %h", bus_if.io_out_data, io_exp);
                    end
                end
            end
        end
    end

    task automatic cpu_idle();
        bus_if.cpu_r     = 1'b0;
        bus_if.cpu_w     = 1'b0;
        bus_if.cpu_addr  = 8'h00;
        bus_if.cpu_wdata = 32'h0;
    endtask

    task automatic cpu_read(input logic [7:0] addr);
        bus_if.cpu_r    = 1'b1;
        bus_if.cpu_w    = 1'b0;
        bus_if.cpu_addr = addr;
        #1;
    endtask

    // Holds dbg_req until dbg_ack; returns the number of cycles waited
    task automatic dbg_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              output int cycles);
        bus_if.dbg_req   = 1'b1;
        bus_if.dbg_we    = we;
        bus_if.dbg_addr  = addr;
        bus_if.dbg_wdata = wdata;
        cycles = 0;
        while (cycles < 40 && !bus_if.dbg_ack) begin
            tick();
            cycles++;
        end
        checks++;
        if (!bus_if.dbg_ack) begin
            errors++;
            $display("FAIL dbg_ack_timeout: got no ack expected ack within 40 cycles");
        end
        bus_if.dbg_req = 1'b0;
    endtask

    task automatic run_to_stall(output int at);
        at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus_if.cpu_stall) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int stall_at;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ram_clear = 1'b1;
        cpu_idle();
        bus_if.dbg_req     = 1'b0;
        bus_if.dbg_we      = 1'b0;
        bus_if.dbg_addr    = 8'h00;
        bus_if.dbg_wdata   = 32'h0;
        bus_if.io_in_data  = 32'h0;
        bus_if.io_in_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cpu_stall", 32'(bus_if.cpu_stall), 32'd0);
        check("rst_dbg_ack", 32'(bus_if.dbg_ack), 32'd0);
        check("rst_dbg_rdata", bus_if.dbg_rdata, 32'h0);
        check("rst_io_out_data", bus_if.io_out_data, 32'h0);
        check("rst_io_out_valid", 32'(bus_if.io_out_valid), 32'd0);
        check("rst_io_in_ready", 32'(bus_if.io_in_ready), 32'd1);
        rst = 1'b0;
        ram_clear = 1'b0;
        tick();
        cpu_read(8'hFE);
        check("status_after_reset", bus_if.cpu_rdata, 32'h0);
        cpu_idle();

        // Debug read with idle CPU: one-cycle latency
        dbg_q.push_back('{1'b1, 32'hDEADBEEF});
        dbg_access(1'b0, 8'h10, 32'h0, cyc);
        check("dbg_read_latency", 32'(cyc), 32'd1);
        cpu_read(8'hFE);
        check("status_in_ack", bus_if.cpu_rdata, 32'h2);
        cpu_idle();
        tick();
        cpu_read(8'hFE);
        check("status_back_idle", bus_if.cpu_rdata, 32'h0);
        cpu_idle();

        // Starvation: CPU busy every cycle, debug write forced through by a stall
        bus_if.cpu_r     = 1'b1;
        bus_if.cpu_addr  = 8'h10;
        bus_if.dbg_req   = 1'b1;
        bus_if.dbg_we    = 1'b1;
        bus_if.dbg_addr  = 8'h20;
        bus_if.dbg_wdata = 32'h12345678;
        dbg_q.push_back('{1'b0, 32'h0});
        #1;
        check("busy_cpu_read", bus_if.cpu_rdata, 32'hDEADBEEF);
        run_to_stall(stall_at);
        check("stall_cycle", 32'(stall_at), 32'd16);
        bus_if.cpu_r     = 1'b0;
        bus_if.cpu_w     = 1'b1;
        bus_if.cpu_addr  = 8'h30;
        bus_if.cpu_wdata = 32'h00000BAD;
        #1;
        check("stall_cpu_rdata", bus_if.cpu_rdata, 32'h0);
        check("stall_mem_a", 32'(bus_if.mem_a), 32'h20);
        tick();
        check("ack_after_stall", 32'(bus_if.dbg_ack), 32'd1);
        check("stall_released", 32'(bus_if.cpu_stall), 32'd0);
        bus_if.dbg_req = 1'b0;
        cpu_idle();
        tick();
        dbg_q.push_back('{1'b1, 32'h12345678});
        dbg_access(1'b0, 8'h20, 32'h0, cyc);
        tick();
        cpu_read(8'h30);
        check("stalled_cpu_write_dropped", bus_if.cpu_rdata, 32'h0);
        cpu_idle();

        // Input register
        bus_if.io_in_valid = 1'b1;
        bus_if.io_in_data  = 32'h00000055;
        tick();
        bus_if.io_in_valid = 1'b0;
        check("in_full_ready", 32'(bus_if.io_in_ready), 32'd0);
        cpu_read(8'hFE);
        check("status_in_full", bus_if.cpu_rdata, 32'h1);
        cpu_idle();
        dbg_q.push_back('{1'b1, 32'h00000055});
        dbg_access(1'b0, 8'hFD, 32'h0, cyc);
        check("dbg_read_keeps_full", 32'(bus_if.io_in_ready), 32'd0);
        tick();
        bus_if.io_in_valid = 1'b1;
        bus_if.io_in_data  = 32'h00000066;
        cpu_read(8'hFD);
        check("cpu_read_in_data", bus_if.cpu_rdata, 32'h00000055);
        tick();
        cpu_idle();
        check("ready_after_drain", 32'(bus_if.io_in_ready), 32'd1);
        tick();
        bus_if.io_in_valid = 1'b0;
        check("held_valid_accepted", 32'(bus_if.io_in_ready), 32'd0);
        cpu_read(8'hFD);
        check("cpu_read_second", bus_if.cpu_rdata, 32'h00000066);
        tick();
        cpu_idle();
        check("ready_after_second", 32'(bus_if.io_in_ready), 32'd1);

        // IO_OUT writes and read-only addresses
        bus_if.cpu_w     = 1'b1;
        bus_if.cpu_addr  = 8'hFC;
        bus_if.cpu_wdata = 32'h0000000A;
        io_q.push_back(32'h0000000A);
        tick();
        cpu_idle();
        check("io_out_pulse_on", 32'(bus_if.io_out_valid), 32'd1);
        tick();
        check("io_out_pulse_off", 32'(bus_if.io_out_valid), 32'd0);
        cpu_read(8'hFC);
        check("cpu_read_io_out", bus_if.cpu_rdata, 32'h0000000A);
        bus_if.cpu_r     = 1'b0;
        bus_if.cpu_w     = 1'b1;
        bus_if.cpu_addr  = 8'hFE;
        bus_if.cpu_wdata = 32'hFFFFFFFF;
        #1;
        check("status_write_mem_we", 32'(bus_if.mem_we), 32'd0);
        tick();
        bus_if.cpu_addr = 8'hFF;
        #1;
        check("addr_ff_write_mem_we", 32'(bus_if.mem_we), 32'd0);
        tick();
        cpu_read(8'hFE);
        check("status_unchanged", bus_if.cpu_rdata, 32'h0);
        cpu_read(8'hFF);
        check("addr_ff_reads_zero", bus_if.cpu_rdata, 32'h0);
        cpu_idle();
        io_q.push_back(32'h00000077);
        dbg_q.push_back('{1'b0, 32'h0});
        dbg_access(1'b1, 8'hFC, 32'h00000077, cyc);
        tick();
        tick();

        // Debug request withdrawn during WAIT
        bus_if.cpu_r     = 1'b1;
        bus_if.cpu_addr  = 8'hFE;
        bus_if.dbg_req   = 1'b1;
        bus_if.dbg_we    = 1'b1;
        bus_if.dbg_addr  = 8'h40;
        bus_if.dbg_wdata = 32'h0000CAFE;
        tick();
        tick();
        check("status_in_wait", bus_if.cpu_rdata, 32'h2);
        tick();
        bus_if.dbg_req = 1'b0;
        cpu_idle();
        #1;
        check("withdrawn_mem_we", 32'(bus_if.mem_we), 32'd0);
        tick();
        cpu_read(8'hFE);
        check("withdrawn_back_idle", bus_if.cpu_rdata, 32'h0);
        cpu_read(8'h40);
        check("withdrawn_no_write", bus_if.cpu_rdata, 32'h0);
        cpu_idle();
        repeat (3) tick();

        // Reset during STALL
        bus_if.cpu_r     = 1'b1;
        bus_if.cpu_addr  = 8'h10;
        bus_if.dbg_req   = 1'b1;
        bus_if.dbg_we    = 1'b1;
        bus_if.dbg_addr  = 8'h50;
        bus_if.dbg_wdata = 32'h0000FACE;
        run_to_stall(stall_at);
        check("second_stall_cycle", 32'(stall_at), 32'd16);
        rst = 1'b1;
        #1;
        check("rst_drops_stall", 32'(bus_if.cpu_stall), 32'd0);
        check("rst_blocks_mem_we", 32'(bus_if.mem_we), 32'd0);
        bus_if.dbg_req = 1'b0;
        cpu_idle();
        tick();
        rst = 1'b0;
        tick();
        cpu_read(8'hFE);
        check("idle_after_rst", bus_if.cpu_rdata, 32'h0);
        cpu_read(8'h50);
        check("ram_unchanged_after_rst", bus_if.cpu_rdata, 32'h0);
        cpu_idle();
        repeat (3) tick();

        check("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
        check("io_queue_drained", 32'(io_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
